// File: rtl/gray_pkg.sv
// gray_pkg: shared types and default widths for the Gray-to-binary arbiter.
//   state_t : arbiter FSM encoding (IDLE / CONV / RESP)
//   GRAY_W  : default Gray/binary data width
//   CNT_W   : default width of the completed-conversion counter
package gray_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int GRAY_W = 4;
    localparam int CNT_W  = 16;

endpackage

// File: rtl/gray_conv_arbiter_if.sv
// gray_conv_arbiter_if: request/response bundle between NREQ Gray sources
// and the shared converter.
//   req_valid/req_gray/req_ready : per-requester valid/ready handshake;
//                                  requester i owns req_gray[i*W +: W]
//   rsp_valid/rsp_bin/rsp_id/rsp_ready : single response channel
//   busy, done_cnt              : status from the converter
//   master : requester/consumer side, slave : converter side
interface gray_conv_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = gray_pkg::GRAY_W,
    parameter int CNTW = gray_pkg::CNT_W
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_gray;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [W-1:0]      rsp_bin;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_ready;
    logic              busy;
    logic [CNTW-1:0]   done_cnt;

    modport master (
        output req_valid, req_gray, rsp_ready,
        input  req_ready, rsp_valid, rsp_bin, rsp_id, busy, done_cnt
    );

    modport slave (
        input  req_valid, req_gray, rsp_ready,
        output req_ready, rsp_valid, rsp_bin, rsp_id, busy, done_cnt
    );
endinterface

// File: rtl/gray_bin_w.sv
// gray_bin_w: combinational Gray-to-binary converter.
//   i_gray : Gray-coded input (W bits)
//   o_bin  : binary value; bit i is the XOR of all Gray bits from i upward
module gray_bin_w #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);
    // Reduction over a shifted copy avoids a bit-to-bit feedback chain
    // inside one vector, which keeps the combinational graph acyclic.
    always_comb begin
        o_bin = '0;
        for (int i = 0; i < W; i++) begin
            o_bin[i] = ^(i_gray >> i);
        end
    end
endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin arbiter in front of one shared
// Gray-to-binary converter; one conversion in flight at a time.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of gray_conv_arbiter_if (requests in, response out,
//           busy and done_cnt status)
// Timing: grant in IDLE at cycle T, rsp_valid at T+2, back in IDLE one cycle
// after the response handshake.
module gray_conv_arbiter
    import gray_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = GRAY_W,
    parameter int CNTW = CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gray_conv_arbiter_if.slave   bus
);
    localparam int IDW = $clog2(NREQ);

    state_t          r_state;
    state_t          w_next;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_id;
    logic [W-1:0]    r_g;
    logic            r_rsp_valid;
    logic [W-1:0]    r_rsp_bin;
    logic [IDW-1:0]  r_rsp_id;
    logic [CNTW-1:0] r_done_cnt;

    logic            w_any;
    logic [IDW-1:0]  w_winner;
    logic [W-1:0]    w_gray_sel;
    logic [W-1:0]    w_bin;
    logic [NREQ-1:0] w_req_ready;

    // First asserted requester at or after ptr, wrapping modulo NREQ.
    // Scanning downward lets the lowest offset overwrite the result.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [IDW-1:0]  p);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NREQ;
            if (v[idx]) res = {1'b1, IDW'(idx)};
        end
        return res;
    endfunction

    assign {w_any, w_winner} = rr_pick(bus.req_valid, r_rr_ptr);
    assign w_gray_sel        = bus.req_gray[w_winner*W +: W];

    gray_bin_w #(.W(W)) u_conv (
        .i_gray (r_g),
        .o_bin  (w_bin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_req_ready = '0;
        case (r_state)
            ST_IDLE: begin
                // rst_n gate keeps the grant strobe low while reset is held.
                if (w_any && rst_n) begin
                    w_req_ready[w_winner] = 1'b1;
                    w_next                = ST_CONV;
                end
            end
            ST_CONV: w_next = ST_RESP;
            ST_RESP: if (bus.rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_g         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_bin   <= '0;
            r_rsp_id    <= '0;
            r_done_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_g      <= w_gray_sel;
                        r_id     <= w_winner;
                        // NREQ need not be a power of two, so wrap explicitly.
                        r_rr_ptr <= (w_winner == IDW'(NREQ - 1)) ? '0
                                                                 : w_winner + IDW'(1);
                    end
                end
                ST_CONV: begin
                    r_rsp_bin   <= w_bin;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_done_cnt  <= r_done_cnt + CNTW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_bin   = r_rsp_bin;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done_cnt  = r_done_cnt;
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with literal expectations. A second instance with a
// 2-bit counter shares all inputs so counter wrap-around is seen quickly.
module tb_gray_conv_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int CNTW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gray_conv_arbiter_if #(.NREQ(NREQ), .W(W), .CNTW(CNTW)) bus ();
    gray_conv_arbiter_if #(.NREQ(NREQ), .W(W), .CNTW(2))    bus2 ();

    assign bus2.req_valid = bus.req_valid;
    assign bus2.req_gray  = bus.req_gray;
    assign bus2.rsp_ready = bus.rsp_ready;

    gray_conv_arbiter #(.NREQ(NREQ), .W(W), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    gray_conv_arbiter #(.NREQ(NREQ), .W(W), .CNTW(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    int tot = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic int g2b(input int g);
        int b;
        b = 0;
        for (int k = 0; k < W; k++) b = b ^ (g >> k);
        return b & ((1 << W) - 1);
    endfunction

    int              m_ptr, m_cnt, m_bin, m_id, m_g, m_wid, m_pick;
    bit              m_busy, m_rv;
    logic [NREQ-1:0] m_exp_rdy;
    int              m_pick_g;

    always_comb m_pick = pick(bus.req_valid, m_ptr);

    always_comb begin
        m_pick_g = 0;
        if (m_pick >= 0) m_pick_g = int'(bus.req_gray[m_pick*W +: W]);
    end

    always_comb begin
        m_exp_rdy = '0;
        if (rst_n && !m_busy && m_pick >= 0) m_exp_rdy[m_pick] = 1'b1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_rv <= 1'b0; m_ptr <= 0; m_cnt <= 0;
            m_bin  <= 0;    m_id <= 0;    m_g   <= 0; m_wid <= 0;
        end else if (!m_busy) begin
            if (m_pick >= 0) begin
                m_busy <= 1'b1;
                m_g    <= m_pick_g;
                m_wid  <= m_pick;
                m_ptr  <= (m_pick + 1) % NREQ;
            end
        end else if (!m_rv) begin
            m_rv  <= 1'b1;
            m_bin <= g2b(m_g);
            m_id  <= m_wid;
        end else if (bus.rsp_ready) begin
            m_rv   <= 1'b0;
            m_busy <= 1'b0;
            m_cnt  <= m_cnt + 1;
        end
    end

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    int glog[$];
    int gcyc[$];

    // Every-cycle comparison against the model, plus grant logging.
    always @(negedge clk) begin
        chk("req_ready",  32'(bus.req_ready), 32'(m_exp_rdy));
        chk("rsp_valid",  32'(bus.rsp_valid), 32'(m_rv));
        chk("rsp_bin",    32'(bus.rsp_bin),   32'(m_bin));
        chk("rsp_id",     32'(bus.rsp_id),    32'(m_id));
        chk("busy",       32'(bus.busy),      32'(m_busy));
        chk("done_cnt",   32'(bus.done_cnt),  32'(m_cnt & 32'hFFFF));
        chk("wrap_cnt",   32'(bus2.done_cnt), 32'(m_cnt & 32'h3));
        if (bus.req_ready != '0) begin
            glog.push_back(oh_idx(bus.req_ready));
            gcyc.push_back(cyc);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_grant(input string nm, output int got, output int gc);
        got = -1; gc = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                got = oh_idx(bus.req_ready); gc = cyc;
                return;
            end
        end
        chk({nm, "_grant_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input string nm, output int rc);
        rc = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin rc = cyc; return; end
        end
        chk({nm, "_rsp_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic req1(input string nm, input int id, input logic [W-1:0] g,
                        input logic [W-1:0] eb);
        int got, gc, rc;
        bus.req_valid     = '0;
        bus.req_valid[id] = 1'b1;
        bus.req_gray[id*W +: W] = g;
        wait_grant(nm, got, gc);
        chk({nm, "_grant"}, 32'(got), 32'(id));
        step();
        bus.req_valid = '0;
        wait_rsp(nm, rc);
        chk({nm, "_latency"}, 32'(rc - gc), 32'd2);
        chk({nm, "_bin"}, 32'(bus.rsp_bin), 32'(eb));
        chk({nm, "_id"},  32'(bus.rsp_id),  32'(id));
        step();
    endtask

    task automatic rr_run(input string nm, input logic [NREQ-1:0] v,
                          input int e0, input int e1, input int e2, input int e3);
        int exp_o[4];
        int rc;
        exp_o = '{e0, e1, e2, e3};
        glog.delete(); gcyc.delete();
        bus.req_valid = v;
        for (int n = 0; n < 40 && glog.size() < 4; n++) begin
            @(negedge clk); #1;
        end
        step();
        bus.req_valid = '0;
        if (glog.size() < 4) chk({nm, "_count"}, 32'(glog.size()), 32'd4);
        else begin
            for (int i = 0; i < 4; i++) chk({nm, "_order"}, 32'(glog[i]), 32'(exp_o[i]));
            for (int i = 1; i < 4; i++) chk({nm, "_spacing"}, 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        end
        wait_rsp(nm, rc);
        step();
    endtask

    logic [W-1:0] sw_g [6];
    logic [W-1:0] sw_b [6];

    initial begin
        int got, gc, rc;
        logic [W-1:0] hold_bin;
        sw_g = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b1000, 4'b1111};
        sw_b = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1111, 4'b1010};
        bus.req_valid = '0;
        bus.req_gray  = '0;
        bus.rsp_ready = 1'b0;

        repeat (3) step();
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_done",      32'(bus.done_cnt),  32'd0);
        chk("rst_bin",       32'(bus.rsp_bin),   32'd0);
        rst_n = 1'b1;
        step();

        // single request, requester 0
        bus.rsp_ready = 1'b1;
        req1("single", 0, 4'b0110, 4'b0100);
        chk("single_done", 32'(bus.done_cnt), 32'd1);

        // conversion sweep on requester 3
        for (int i = 0; i < 6; i++) req1("sweep", 3, sw_g[i], sw_b[i]);
        chk("sweep_done", 32'(bus.done_cnt),  32'd7);
        chk("sweep_wrap", 32'(bus2.done_cnt), 32'd3);

        // round-robin ordering
        bus.req_gray = 16'h9A5C;
        rr_run("rr0101", 4'b0101, 0, 2, 0, 2);
        rr_run("rr1111", 4'b1111, 3, 0, 1, 2);
        chk("rr_done", 32'(bus.done_cnt), 32'd15);

        // backpressure while in RESP
        bus.rsp_ready = 1'b0;
        bus.req_gray[1*W +: W] = 4'b0101;
        bus.req_valid = 4'b0010;
        wait_grant("bp", got, gc);
        chk("bp_grant", 32'(got), 32'd1);
        step();
        bus.req_valid = 4'b1111;
        wait_rsp("bp", rc);
        hold_bin = bus.rsp_bin;
        chk("bp_bin", 32'(hold_bin), 32'b0110);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_hold",  32'(bus.rsp_bin),   32'(hold_bin));
            chk("bp_id",    32'(bus.rsp_id),    32'd1);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_busy",  32'(bus.busy),      32'd1);
            chk("bp_done",  32'(bus.done_cnt),  32'd15);
        end
        step();
        bus.rsp_ready = 1'b1;
        wait_grant("bp2", got, gc);
        chk("bp2_grant", 32'(got), 32'd2);
        chk("bp2_done",  32'(bus.done_cnt), 32'd16);
        step();
        bus.req_valid = '0;
        wait_rsp("bp2", rc);
        step();
        chk("bp_done_end", 32'(bus.done_cnt),  32'd17);
        chk("wrap_end",    32'(bus2.done_cnt), 32'd1);

        // reset during CONV
        bus.req_gray[2*W +: W] = 4'b1011;
        bus.req_valid = 4'b0100;
        wait_grant("mid", got, gc);
        chk("mid_grant", 32'(got), 32'd2);
        step();
        rst_n = 1'b0;
        bus.req_valid = '0;
        #1;
        chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_busy",      32'(bus.busy),      32'd0);
        chk("mid_done",      32'(bus.done_cnt),  32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        bus.req_valid = 4'b1111;
        wait_grant("post", got, gc);
        chk("post_grant", 32'(got), 32'd0);
        step();
        bus.req_valid = '0;
        wait_rsp("post", rc);
        step();
        chk("post_done", 32'(bus.done_cnt), 32'd1);

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
- Shares one Gray-to-binary conversion datapath between NREQ requesters.
- Arbitration is round-robin. Each requester uses a valid/ready handshake.
- One conversion is in flight at a time. The response carries the binary value and the requester ID.
- Sits between multiple Gray-coded sources (e.g. async FIFO pointers) and a single shared converter.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 4, Gray/binary data width.
- IDW, $clog2(NREQ), requester ID width (derived; not overridden).
- CNTW, 16, width of the completed-conversion counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset: asynchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_gray  in  NREQ*W  packed Gray inputs; requester i occupies bits [i*W +: W].
- req_ready  out  NREQ  per-requester accept strobe, one-hot or zero.
- rsp_valid  out  1  response valid.
- rsp_bin  out  W  converted binary value.
- rsp_id  out  IDW  index of the requester that was served.
- rsp_ready  in  1  downstream accepts the response.
- busy  out  1  high whenever the FSM is not in IDLE.
- done_cnt  out  CNTW  count of completed responses; wraps.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; rr_ptr=0; req_ready=0; rsp_valid=0; rsp_bin=0; rsp_id=0; busy=0; done_cnt=0; g_reg=0.
- FSM states: IDLE, CONV, RESP.
- IDLE:
  - If any req_valid is set, pick the winner: the first set bit scanning from rr_ptr upward, wrapping modulo NREQ.
  - req_ready[winner] is driven combinationally high in this cycle only. The handshake occurs here.
  - Capture g_reg=req_gray[winner] and id_reg=winner.
  - Set rr_ptr=(winner+1) mod NREQ. Go to CONV.
  - If no req_valid is set, stay in IDLE; req_ready=0; rr_ptr unchanged.
- CONV:
  - Binary result b[W-1]=g[W-1]; b[i]=b[i+1]^g[i].
  - Register the result into rsp_bin and id_reg into rsp_id; set rsp_valid=1. Go to RESP.
  - req_ready=0.
- RESP:
  - Hold rsp_valid, rsp_bin and rsp_id stable until rsp_ready=1.
  - On rsp_valid&rsp_ready: clear rsp_valid; done_cnt+=1 (wraps at 2^CNTW-1 to 0); go to IDLE.
  - rsp_bin and rsp_id keep their last value after rsp_valid falls.
- Latency: request accepted at cycle T, rsp_valid high at T+2.
- Throughput: minimum 3 cycles per conversion (accept, convert, respond with rsp_ready already high).
- req_ready is never asserted outside IDLE. A requester holding req_valid high simply waits.
- Requesters must hold req_gray stable while req_valid=1 and req_ready=0. Only the value present at the handshake cycle is used.
- Dropping req_valid before the grant is allowed and never produces a grant.
- Simultaneous requests: exactly one grant per IDLE cycle. Starvation is impossible: every asserted requester is served within NREQ grants.
- rr_ptr wrap: winner=NREQ-1 sets rr_ptr=0.
- rsp_ready high while not in RESP is ignored.
- busy = (state != IDLE).
- Reset mid-operation (any state): immediate return to reset values. An in-flight conversion is discarded and does not count.
- Unused FSM encodings recover to IDLE.

Decomposition:
- Shared package gray_pkg holds:
  - state enum/localparams ST_IDLE=2'd0, ST_CONV=2'd1, ST_RESP=2'd2;
  - default widths GRAY_W=4 and CNT_W=16.
- Sub-module gray_bin_w: purely combinational, parameterised by W. Instantiated once on g_reg.
- The round-robin select stays inline as a function.

Test Plan:
- Single request: after reset, req_valid=0001, req_gray[3:0]=0110 -> req_ready=0001 in the same cycle; 2 cycles later rsp_valid=1, rsp_bin=0100, rsp_id=0; with rsp_ready=1, done_cnt becomes 1.
- Conversion sweep on requester 3: Gray 0000,0001,0011,0010,1000,1111 -> binary 0000,0001,0010,0011,1111,1010; rsp_id=3 each time.
- Round-robin: req_valid=0101 held continuously, rsp_ready=1 -> grant order 0,2,0,2. Then req_valid=1111 from rr_ptr=3 -> grant order 3,0,1,2. Grants are one every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles while in RESP -> rsp_valid, rsp_bin and rsp_id stay stable; req_ready stays 0 despite req_valid=1111; busy=1; done_cnt does not change until the handshake.
- Reset mid-operation: assert rst_n=0 during CONV with g_reg=1011 -> outputs clear immediately; no response appears after release; done_cnt=0; the first grant after release goes to requester 0.
- Counter wrap: force/preload done_cnt to 16'hFFFF, complete one conversion -> done_cnt=0.
